ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000: number of Clk cycles the PS/2 clock is held low before a request (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 750000: maximum Clk cycles allowed between device falling edges (15 ms at 50 MHz).
REQ-003 Clk  input  1  system clock; all state changes occur on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to send tx_byte; sampled only in IDLE.
REQ-006 tx_byte  input  8  command byte to send to the keyboard (e.g. 0xED LED set).
REQ-007 ps2clock  input  1  raw PS/2 clock line (asynchronous).
REQ-008 data  input  1  raw PS/2 data line (asynchronous).
REQ-009 ps2clk_oe  output  1  1 = drive PS/2 clock low; 0 = release the line (open-drain).
REQ-010 ps2data_oe  output  1  1 = drive PS/2 data low; 0 = release the line (open-drain).
REQ-011 busy  output  1  high from the start acceptance cycle until the done/err cycle inclusive.
REQ-012 done  output  1  one-cycle pulse: frame sent and device ACK received.
REQ-013 err  output  1  one-cycle pulse: missing ACK or timeout.

Function
REQ-014 ps2clock and data SHALL each pass through a 2-FF synchronizer; a falling edge SHALL be flagged when the previous synced clock is 1 and the current synced clock is 0.
REQ-015 States: IDLE, INHIBIT, RTS, SEND, ACK, DONE, ERR.
REQ-016 IDLE: ps2clk_oe=0, ps2data_oe=0, busy=0; start=1 SHALL latch tx_byte, compute odd parity (~^tx_byte), and move to INHIBIT.
REQ-017 INHIBIT: ps2clk_oe=1, ps2data_oe=0 for exactly INHIBIT_CYCLES cycles, then RTS.
REQ-018 RTS: ps2clk_oe=1, ps2data_oe=1 (start bit) for exactly 1 cycle, then SEND.
REQ-019 SEND: ps2clk_oe=0; the 4-bit edge counter starts at 0 and increments on each falling edge.
REQ-020 SEND falling edges 1-8 SHALL present data bits 0-7, LSB first, as ps2data_oe = ~bit on the cycle after the edge flag.
REQ-021 SEND falling edge 9 SHALL present the parity bit; edge 10 SHALL release data (stop bit, ps2data_oe=0) and move to ACK.
REQ-022 ACK: on the next falling edge, synced data=0 SHALL go to DONE; synced data=1 SHALL go to ERR.
REQ-023 DONE and ERR SHALL each last one cycle (asserting done or err respectively), release both lines, and return to IDLE.
REQ-024 A timeout counter SHALL clear on entry to SEND and on every falling edge; reaching TIMEOUT_CYCLES in SEND or ACK SHALL go to ERR.
REQ-025 start while busy=1 SHALL be ignored; tx_byte changes after acceptance SHALL not affect the frame in progress.
REQ-026 done and err SHALL never be asserted in the same cycle.
REQ-027 Falling edges seen in IDLE, INHIBIT or RTS SHALL be ignored.

Reset
REQ-028 Reset=1 SHALL immediately force IDLE, ps2clk_oe=0, ps2data_oe=0, busy=0, done=0, err=0, all counters 0, and synchronizer flops to 1.
REQ-029 Reset mid-frame SHALL release both lines asynchronously; after deassertion the block SHALL wait in IDLE for a new start.

Verification
REQ-030 start with tx_byte=0xED; device model clocks 11 edges and ACKs low -> ps2clk_oe high for 5000 cycles, then start bit, then data bits 1,0,1,1,0,1,1,1, parity 1, stop released; done pulses once; busy drops the next cycle.
REQ-031 start with tx_byte=0x00 -> eight 0 data bits (ps2data_oe=1), parity bit 1 (ps2data_oe=0), done after ACK.
REQ-032 Device gives 11 edges but holds data high at ACK -> err pulses once, done stays 0, both oe signals 0.
REQ-033 Device stops after 4 falling edges -> err exactly TIMEOUT_CYCLES after the 4th edge flag; lines released.
REQ-034 start pulsed again with tx_byte=0xFF during SEND of 0xED -> transmitted bits unchanged; no second frame.
REQ-035 Reset asserted at edge 6 -> same-cycle release of ps2clk_oe/ps2data_oe, busy=0; a subsequent start of 0xF4 completes with done.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts out a command byte with odd parity on device clock edges and checks
// the device acknowledge bit. Both PS/2 lines are open-drain; the *_oe outputs
// pull the corresponding line low when high.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       ps2clock,
    input  logic       data,
    output logic       ps2clk_oe,
    output logic       ps2data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        DONE,
        ERR
    } state_t;

    state_t             state;
    logic [7:0]         shreg;
    logic               parity;
    logic [INH_W-1:0]   inh_cnt;
    logic [3:0]         edge_cnt;
    logic [TO_W-1:0]    to_cnt;

    logic               clk_meta;
    logic               clk_sync;
    logic               clk_prev;
    logic               data_meta;
    logic               data_sync;
    logic               fall_c;

    // Two-flop synchronizers for both raw lines plus a history flop for edge detect
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2clock;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= data;
            data_sync <= data_meta;
        end
    end

    assign fall_c = clk_prev & ~clk_sync;

    // Transmit sequencer; every output is a register updated with the state
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            shreg      <= 8'd0;
            parity     <= 1'b0;
            inh_cnt    <= '0;
            edge_cnt   <= 4'd0;
            to_cnt     <= '0;
            ps2clk_oe  <= 1'b0;
            ps2data_oe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    ps2clk_oe  <= 1'b0;
                    ps2data_oe <= 1'b0;
                    busy       <= 1'b0;
                    if (start) begin
                        shreg     <= tx_byte;
                        parity    <= ~^tx_byte;
                        inh_cnt   <= '0;
                        busy      <= 1'b1;
                        ps2clk_oe <= 1'b1;
                        state     <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                        ps2data_oe <= 1'b1;
                        state      <= RTS;
                    end else begin
                        inh_cnt <= inh_cnt + INH_W'(1);
                    end
                end

                RTS: begin
                    // Release the clock, keep data low as the start bit
                    ps2clk_oe <= 1'b0;
                    edge_cnt  <= 4'd0;
                    to_cnt    <= '0;
                    state     <= SEND;
                end

                SEND: begin
                    if (fall_c) begin
                        edge_cnt <= edge_cnt + 4'd1;
                        to_cnt   <= '0;
                        if (edge_cnt < 4'd8) begin
                            ps2data_oe <= ~shreg[edge_cnt[2:0]];
                        end else if (edge_cnt == 4'd8) begin
                            ps2data_oe <= ~parity;
                        end else begin
                            ps2data_oe <= 1'b0;
                            state      <= ACK;
                        end
                    end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 2)) begin
                        // Counter restarts the cycle after an edge flag, so err
                        // lands exactly TIMEOUT_CYCLES cycles after that flag
                        ps2data_oe <= 1'b0;
                        err        <= 1'b1;
                        state      <= ERR;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                ACK: begin
                    if (fall_c) begin
                        to_cnt <= '0;
                        if (data_sync) begin
                            err   <= 1'b1;
                            state <= ERR;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 2)) begin
                        err   <= 1'b1;
                        state <= ERR;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                DONE, ERR: begin
                    ps2clk_oe  <= 1'b0;
                    ps2data_oe <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    ps2clk_oe  <= 1'b0;
                    ps2data_oe <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on wired-AND lines, with the
// expected host frame built as {stop, parity, byte, start}.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TO  = 300;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] tx_byte;
    logic       dev_clk;
    logic       dev_data;
    logic       clk_line;
    logic       data_line;
    logic       ps2clk_oe;
    logic       ps2data_oe;
    logic       busy;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    assign clk_line  = dev_clk & ~ps2clk_oe;
    assign data_line = dev_data & ~ps2data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .Clk       (clk),
        .Reset     (rst),
        .start     (start),
        .tx_byte   (tx_byte),
        .ps2clock  (clk_line),
        .data      (data_line),
        .ps2clk_oe (ps2clk_oe),
        .ps2data_oe(ps2data_oe),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // done and err must never coincide
    always @(negedge clk) begin
        if (done || err) check("done_err_excl", 32'(done & err), 32'd0);
    end

    // Issue start and wait until the host has entered the data phase
    task automatic launch(input logic [7:0] b);
        int i;
        tx_byte = b;
        start   = 1'b1;
        tick(1);
        start   = 1'b0;
        tx_byte = 8'($urandom);
        i = 0;
        while (!(busy && !ps2clk_oe) && i < INH + 20) begin
            tick(1);
            i++;
        end
        check("reach_send", 32'(busy && !ps2clk_oe), 32'd1);
    endtask

    task automatic run_frame(input logic [7:0] b, input logic ack, input int h, input bit inject);
        logic [10:0] frame;
        logic        e;
        int          cnt;
        int          mark;
        int          n_done;
        int          n_err;
        frame = {1'b1, ~^b, b, 1'b0};

        tx_byte = b;
        start   = 1'b1;
        tick(1);
        start   = 1'b0;
        tx_byte = 8'($urandom);
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_clk_oe", 32'(ps2clk_oe), 32'd1);

        cnt = 0;
        for (int i = 0; i < INH + 50; i++) begin
            if (ps2clk_oe && !ps2data_oe && busy) cnt++;
            else break;
            tick(1);
        end
        check("inhibit_len", 32'(cnt), 32'(INH));
        check("rts_lines", 32'({ps2clk_oe, ps2data_oe}), 32'd3);
        tick(1);
        check("send_clk_rel", 32'(ps2clk_oe), 32'd0);
        e = ~frame[0];
        check("start_bit", 32'(ps2data_oe), 32'(e));

        for (int n = 1; n <= 10; n++) begin
            tick(2);
            dev_clk = 1'b0;
            for (int c = 0; c < h; c++) begin
                if (inject && n == 4) begin
                    start   = (c == 0);
                    tx_byte = 8'hFF;
                end
                tick(1);
            end
            start = 1'b0;
            e = ~frame[n];
            check($sformatf("edge%0d_oe", n), 32'(ps2data_oe), 32'(e));
            check($sformatf("edge%0d_busy", n), 32'(busy), 32'd1);
            dev_clk = 1'b1;
            tick(h);
        end

        n_done   = 0;
        n_err    = 0;
        mark     = -1;
        dev_data = ack;
        dev_clk  = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick(1);
            if (mark >= 0 && c == mark + 1) begin
                check("busy_drop", 32'(busy), 32'd0);
                check("lines_released", 32'({ps2clk_oe, ps2data_oe}), 32'd0);
            end
            if (done || err) begin
                check("busy_inclusive", 32'(busy), 32'd1);
                mark = c;
                if (done) n_done++;
                if (err) n_err++;
            end
        end
        check("done_count", 32'(n_done), ack ? 32'd0 : 32'd1);
        check("err_count", 32'(n_err), ack ? 32'd1 : 32'd0);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        tick(h);

        if (inject) begin
            cnt = 0;
            for (int c = 0; c < 30; c++) begin
                if (busy || ps2clk_oe) cnt++;
                tick(1);
            end
            check("no_second_frame", 32'(cnt), 32'd0);
        end
    endtask

    task automatic run_timeout(input logic [7:0] b, input int h);
        int seen;
        int n_done;
        launch(b);
        for (int n = 1; n <= 3; n++) begin
            tick(2);
            dev_clk = 1'b0;
            tick(h);
            dev_clk = 1'b1;
            tick(h);
        end
        tick(2);
        dev_clk = 1'b0;
        seen    = -1;
        n_done  = 0;
        for (int c = 1; c <= TO + 10; c++) begin
            tick(1);
            if (c == h) dev_clk = 1'b1;
            if (done) n_done++;
            if (err && seen < 0) begin
                seen = c;
                check("to_lines_released", 32'({ps2clk_oe, ps2data_oe}), 32'd0);
            end
        end
        // Edge flag is visible two samples after the line drops
        check("to_latency", 32'(seen), 32'(TO + 2));
        check("to_no_done", 32'(n_done), 32'd0);
        check("to_idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic run_reset_mid(input int h);
        launch(8'hED);
        for (int n = 1; n <= 5; n++) begin
            tick(2);
            dev_clk = 1'b0;
            tick(h);
            dev_clk = 1'b1;
            tick(h);
        end
        tick(2);
        dev_clk = 1'b0;
        tick(3);
        rst = 1'b1;
        #1;
        check("rst_clk_oe", 32'(ps2clk_oe), 32'd0);
        check("rst_data_oe", 32'(ps2data_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_err", 32'({done, err}), 32'd0);
        tick(2);
        dev_clk = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(10);
        check("rst_wait_busy", 32'(busy), 32'd0);
        check("rst_wait_clk_oe", 32'(ps2clk_oe), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        tx_byte  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        tick(3);
        check("reset_lines", 32'({ps2clk_oe, ps2data_oe}), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done_err", 32'({done, err}), 32'd0);
        rst = 1'b0;
        tick(3);

        run_frame(8'hED, 1'b0, 8, 1'b0);
        run_frame(8'h00, 1'b0, 6, 1'b0);
        run_frame(8'hED, 1'b1, 7, 1'b0);
        run_frame(8'hED, 1'b0, 8, 1'b1);
        run_timeout(8'hED, 6);
        tick(5);
        run_reset_mid(6);
        run_frame(8'hF4, 1'b0, 7, 1'b0);

        for (int k = 0; k < 6; k++) begin
            logic [7:0] b;
            logic       a;
            int         h;
            b = 8'($urandom);
            a = ($urandom_range(0, 3) == 0);
            h = $urandom_range(5, 10);
            run_frame(b, a, h, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
